// File: rtl/fft_pkg.sv
// Shared definitions for the shared-butterfly DIT FFT datapath.
// State codes are decoded by the downstream address generator.
package fft_pkg;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'b00,
    ST_COMP   = 2'b01,
    ST_UNLOAD = 2'b10,
    ST_IDLE   = 2'b11
  } fft_state_e;

  localparam int FFT_AW = 13;
  localparam int N      = 2 ** FFT_AW;

  function automatic int fft_len(input int aw);
    return 1 << aw;
  endfunction

endpackage

// File: rtl/fft_ctrl_dit_valid_delay.sv
// Fixed-depth strobe delay line matching the butterfly
// read-to-write latency; cleared by synchronous reset.
module valid_delay #(
  parameter int DEPTH = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] sr;

  always_ff @(posedge clk) begin
    if (rst) begin
      sr <= '0;
    end else begin
      sr[0] <= d;
      for (int i = 1; i < DEPTH; i++)
        sr[i] <= sr[i-1];
    end
  end

  assign q = sr[DEPTH-1];

endmodule

// File: rtl/fft_ctrl_dit.sv
// Sequencer for the shared-butterfly DIT FFT: load N samples,
// run ADDR_WIDTH radix-2 stages, then stream the results out.
module fft_ctrl_dit
  import fft_pkg::*;
#(
  parameter int ADDR_WIDTH = FFT_AW,
  parameter int PIPE_LAT   = 3,
  localparam int SW = (ADDR_WIDTH > 1) ? $clog2(ADDR_WIDTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [1:0]            state,
  output logic [ADDR_WIDTH-1:0] count,
  output logic                  count_over,
  output logic [SW-1:0]         stage,
  output logic                  bf_en,
  output logic                  mem_we,
  output logic                  mem_re,
  output logic                  busy,
  output logic                  done
);

  localparam int LEN = fft_len(ADDR_WIDTH);
  localparam int DW  = $clog2(PIPE_LAT + 1);

  localparam logic [ADDR_WIDTH-1:0] CNT_LAST =
    ADDR_WIDTH'(LEN - 1);
  localparam logic [SW-1:0] STG_LAST = SW'(ADDR_WIDTH - 1);
  localparam logic [DW-1:0] DRN_LAST = DW'(PIPE_LAT - 1);

  fft_state_e            st_q;
  logic [ADDR_WIDTH-1:0] count_q;
  logic [SW-1:0]         stage_q;
  logic                  drain_q;
  logic [DW-1:0]         dcnt_q;
  logic                  last_q;
  logic                  ov_q;
  logic                  done_q;
  logic                  dly_we;

  logic at_last;
  logic ld_hs;
  logic bf_run;
  logic rd;
  logic out_hs;

  assign at_last = (count_q == CNT_LAST);
  assign ld_hs   = (st_q == ST_LOAD) & in_valid;
  assign bf_run  = (st_q == ST_COMP) & ~drain_q;
  assign rd      = (st_q == ST_UNLOAD)
                 & (out_ready | ~ov_q) & ~last_q;
  assign out_hs  = (st_q == ST_UNLOAD) & ov_q & out_ready;

  valid_delay #(
    .DEPTH (PIPE_LAT)
  ) u_we_dly (
    .clk (clk),
    .rst (rst),
    .d   (bf_run),
    .q   (dly_we)
  );

  assign state      = st_q;
  assign count      = count_q;
  assign stage      = stage_q;
  assign in_ready   = (st_q == ST_LOAD);
  assign out_valid  = ov_q;
  assign bf_en      = bf_run;
  assign mem_re     = rd;
  assign busy       = (st_q != ST_IDLE);
  assign done       = done_q;
  assign count_over = (ld_hs | bf_run | rd) & at_last;
  assign mem_we     = ld_hs | ((st_q == ST_COMP) & dly_we);

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q    <= ST_IDLE;
      count_q <= '0;
      stage_q <= '0;
      drain_q <= 1'b0;
      dcnt_q  <= '0;
      last_q  <= 1'b0;
      ov_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (st_q)
        ST_IDLE: begin
          if (start) begin
            st_q    <= ST_LOAD;
            count_q <= '0;
          end
        end
        ST_LOAD: begin
          if (ld_hs) begin
            if (at_last) begin
              st_q    <= ST_COMP;
              count_q <= '0;
              stage_q <= '0;
              drain_q <= 1'b0;
            end else begin
              count_q <= count_q + 1'b1;
            end
          end
        end
        ST_COMP: begin
          if (!drain_q) begin
            if (at_last) begin
              count_q <= '0;
              drain_q <= 1'b1;
              dcnt_q  <= '0;
            end else begin
              count_q <= count_q + 1'b1;
            end
          end else if (dcnt_q == DRN_LAST) begin
            // all writes of this stage have landed
            drain_q <= 1'b0;
            if (stage_q == STG_LAST) begin
              st_q   <= ST_UNLOAD;
              last_q <= 1'b0;
              ov_q   <= 1'b0;
            end else begin
              stage_q <= stage_q + 1'b1;
            end
          end else begin
            dcnt_q <= dcnt_q + 1'b1;
          end
        end
        ST_UNLOAD: begin
          if (rd) begin
            if (at_last) begin
              count_q <= '0;
              last_q  <= 1'b1;
            end else begin
              count_q <= count_q + 1'b1;
            end
          end
          if (rd)
            ov_q <= 1'b1;
          else if (out_ready)
            ov_q <= 1'b0;
          // any handshake after the final read is the last sample
          if (out_hs && last_q) begin
            st_q   <= ST_IDLE;
            done_q <= 1'b1;
            ov_q   <= 1'b0;
            last_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/fft_ctrl_dit.md
Name: fft_ctrl_dit

Overview:
Top-level sequencer for the shared-butterfly DIT FFT.
- Accepts N = 2**ADDR_WIDTH input samples through a valid/ready handshake.
- Runs ADDR_WIDTH radix-2 stages on the single butterfly.
- Streams the N results out through a valid/ready handshake.
- Drives state/count/count_over/stage into the DIT address generator directly downstream, plus memory write/read strobes and butterfly enable.

Parameters:
ADDR_WIDTH, 13, log2 of FFT length; N = 2**ADDR_WIDTH.
PIPE_LAT, 3, read-to-write latency of the butterfly path in cycles; must equal the address generator's write-address delay (3).

Ports:
clk  in  1  clock; one clock domain.
rst  in  1  synchronous, active-high reset.
start  in  1  begin a transform; honoured only in IDLE.
in_valid  in  1  input sample valid.
in_ready  out  1  high throughout LOAD.
out_valid  out  1  output sample valid; data is the RAM read port.
out_ready  in  1  consumer accepts output.
state  out  2  00 LOAD, 01 COMPUTE, 10 UNLOAD, 11 IDLE.
count  out  ADDR_WIDTH  sample/read index within the current phase or stage.
count_over  out  1  combinational; high when count==N-1 and count advances this cycle.
stage  out  $clog2(ADDR_WIDTH)  current butterfly stage, 0..ADDR_WIDTH-1.
bf_en  out  1  butterfly operand read strobe (COMPUTE RUN only).
mem_we  out  1  data RAM write enable.
mem_re  out  1  data RAM read enable (UNLOAD only; RAM output holds while low).
busy  out  1  state != IDLE.
done  out  1  one-cycle pulse at transform completion.

Behaviour:
- Reset values: state=11, count=0, stage=0, PIPE_LAT delay line cleared, out_valid=0, done=0. Consequently in_ready, bf_en, mem_we, mem_re, count_over and busy are all 0.
- Reset asserted mid-operation aborts the transform: IDLE on the next cycle, no done pulse.
- IDLE: start -> LOAD on the next cycle with count=0. Start while busy is ignored.
- LOAD:
  - in_ready=1; mem_we = in_valid.
  - count increments only on a handshake.
  - Handshake at count==N-1: count_over=1, count->0, stage->0, state->COMPUTE.
- COMPUTE has two internal sub-phases, RUN and DRAIN; state output stays 01 in both.
  - RUN: bf_en=1; count increments every cycle; count[0] selects the x0/x1 read.
  - RUN at count==N-1: count_over=1 for exactly one cycle, count->0, enter DRAIN.
  - DRAIN: exactly PIPE_LAT cycles; bf_en=0; count held at 0; count_over=0.
  - End of DRAIN: if stage==ADDR_WIDTH-1, go to UNLOAD with stage held; otherwise stage+1 and back to RUN.
  - Each stage lasts N+PIPE_LAT cycles.
  - mem_we in COMPUTE = bf_en delayed exactly PIPE_LAT cycles, so DRAIN guarantees all stage writes land before the next stage reads.
- UNLOAD:
  - mem_re = (out_ready | !out_valid) & !last_issued; count increments on mem_re.
  - out_valid is set the cycle after mem_re; it clears when out_ready is high and no new mem_re occurred.
  - No sample is dropped or duplicated under any out_ready pattern.
  - mem_re at count==N-1: count_over=1, last_issued set, count->0.
  - After the last output handshake: state->IDLE and done=1, both in the same (next) cycle.
- Width rules: count wraps by explicit reload, never by overflow; stage never exceeds ADDR_WIDTH-1.
- Simultaneous events: in_valid outside LOAD and out_ready outside UNLOAD are ignored.

Decomposition:
- Package fft_pkg holds:
  - state encodings ST_LOAD=2'b00, ST_COMP=2'b01, ST_UNLOAD=2'b10, ST_IDLE=2'b11, shared with the address generator;
  - the localparam N derived from ADDR_WIDTH.
- Sub-module valid_delay #(DEPTH=PIPE_LAT) provides the bf_en -> mem_we shift register with synchronous reset clear.

Test Plan:
1. Reset check (ADDR_WIDTH=3, PIPE_LAT=3): after rst -> state=11, count=0, stage=0, in_ready=0, out_valid=0, busy=0, mem_we=0.
2. LOAD with in_valid low on the 3rd sample -> count holds 2 during the gap; 8 mem_we pulses; count_over on the 8th handshake; next cycle state=01, stage=0.
3. COMPUTE -> exactly 33 cycles in state 01; count_over pulses at cycles 7, 18, 29; stage sequence 0,1,2; 24 mem_we pulses, each 3 cycles after its bf_en.
4. UNLOAD with out_ready pattern 1,0,0,1,1,0,1,... -> 8 output handshakes with addresses 0..7 in order, no duplicates; done pulses with state=11 the cycle after the 8th handshake.
5. start asserted during COMPUTE -> no effect. rst asserted at stage 1 -> state=11 next cycle. A fresh run then completes all 3 stages and 8 outputs correctly.
6. ADDR_WIDTH=13 smoke test -> COMPUTE lasts 13*(8192+3)=106535 cycles; 13 count_over pulses; stage ends at 12.
